recepcion: RTL and testbench

//  UART receiver for the Bluetooth serial link; the counterpart of the transmision TX block.

---
 rtl/recepcion_if.sv | 20 ++
 rtl/recepcion.sv | 180 ++++++++++++++++++
 tb/tb_recepcion.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/recepcion_if.sv
// Consumer-side bundle of the recepcion UART receiver: received byte, status pulses and read strobe.
// Carries par_err only when RECEPCION_PARITY_EN is defined.
interface recepcion_if;
  logic       rd;
  logic [7:0] dout;
  logic       avail;
  logic       done;
  logic       busy;
  logic       frame_err;
  logic       overrun;
`ifdef RECEPCION_PARITY_EN
  logic       par_err;

  modport master (input rd, output dout, avail, done, busy, frame_err, overrun, par_err);
  modport slave  (output rd, input dout, avail, done, busy, frame_err, overrun, par_err);
`else
  modport master (input rd, output dout, avail, done, busy, frame_err, overrun);
  modport slave  (output rd, input dout, avail, done, busy, frame_err, overrun);
`endif
endinterface

// File: rtl/recepcion.sv
// UART receiver (8N1, LSB first) with mid-bit sampling and avail/rd handshake.
// Define RECEPCION_PARITY_EN to build the 8E1 variant with a PARITY state and par_err.
module recepcion #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic         clk_in,
  input  logic         reset,
  input  logic         rx,
  recepcion_if.master  bus
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef RECEPCION_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [2:0]      idx_reg, idx_next;
  logic [7:0]      shift_reg, shift_next;
  logic            sync_reg, rx_s, rx_q;
  logic [2:0]      fill_reg;
  logic [7:0]      dout_reg;
  logic            avail_reg, done_reg, ferr_reg, overrun_reg;
  logic            good, ferr;
  logic            start_edge;
`ifdef RECEPCION_PARITY_EN
  logic            par_reg, par_next;
  logic            perr, perr_reg;
`endif

  // fill_reg keeps the reset value of the synchroniser from looking like a falling edge
  assign start_edge = fill_reg[2] && rx_q && !rx_s;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    good       = 1'b0;
    ferr       = 1'b0;
`ifdef RECEPCION_PARITY_EN
    par_next   = par_reg;
    perr       = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (start_edge) state_next = START;
      end
      START: begin
        if (cnt_reg == HALF_END) begin
          cnt_next = '0;
          idx_next = '0;
          state_next = rx_s ? IDLE : DATA;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      DATA: begin
        if (cnt_reg == BIT_END) begin
          cnt_next   = '0;
          shift_next = {rx_s, shift_reg[7:1]};
          idx_next   = idx_reg + 3'd1;
          if (idx_reg == 3'd7) begin
`ifdef RECEPCION_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
`ifdef RECEPCION_PARITY_EN
      PARITY: begin
        if (cnt_reg == BIT_END) begin
          cnt_next   = '0;
          par_next   = rx_s;
          state_next = STOP;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
`endif
      STOP: begin
        if (cnt_reg == BIT_END) begin
          cnt_next = '0;
          if (!rx_s) begin
            ferr       = 1'b1;
            state_next = BREAK;
          end else begin
            state_next = IDLE;
`ifdef RECEPCION_PARITY_EN
            // even parity: data bits XOR parity bit must be zero
            if ((^shift_reg) != par_reg) perr = 1'b1;
            else                         good = 1'b1;
`else
            good = 1'b1;
`endif
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      BREAK: begin
        cnt_next = '0;
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      sync_reg    <= 1'b1;
      rx_s        <= 1'b1;
      rx_q        <= 1'b1;
      fill_reg    <= '0;
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      idx_reg     <= '0;
      shift_reg   <= '0;
      dout_reg    <= '0;
      avail_reg   <= 1'b0;
      done_reg    <= 1'b0;
      ferr_reg    <= 1'b0;
      overrun_reg <= 1'b0;
`ifdef RECEPCION_PARITY_EN
      par_reg     <= 1'b0;
      perr_reg    <= 1'b0;
`endif
    end else begin
      sync_reg  <= rx;
      rx_s      <= sync_reg;
      rx_q      <= rx_s;
      fill_reg  <= {fill_reg[1:0], 1'b1};
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      done_reg  <= good;
      ferr_reg  <= ferr;
`ifdef RECEPCION_PARITY_EN
      par_reg   <= par_next;
      perr_reg  <= perr;
`endif
      if (good) dout_reg <= shift_reg;

      if (good)        avail_reg <= 1'b1;
      else if (bus.rd) avail_reg <= 1'b0;

      // a read in the completion cycle consumes the old byte, so no overrun
      if (good && avail_reg && !bus.rd) overrun_reg <= 1'b1;
      else if (bus.rd)                  overrun_reg <= 1'b0;
    end
  end

  assign bus.dout      = dout_reg;
  assign bus.avail     = avail_reg;
  assign bus.done      = done_reg;
  assign bus.busy      = (state_reg != IDLE);
  assign bus.frame_err = ferr_reg;
  assign bus.overrun   = overrun_reg;
`ifdef RECEPCION_PARITY_EN
  assign bus.par_err   = perr_reg;
`endif

endmodule

// File: tb/tb_recepcion.sv
// Scoreboard bench for recepcion at CLKS_PER_BIT=16; RECEPCION_PARITY_EN adds an 8E1 parity case.
`timescale 1ns/1ps
module tb_recepcion;
  localparam int CPB = 16;
`ifdef RECEPCION_PARITY_EN
  localparam int LAT = 3 + 10 * CPB + CPB / 2;
`else
  localparam int LAT = 3 + 9 * CPB + CPB / 2;
`endif

  logic clk_in = 1'b0;
  logic reset  = 1'b0;
  logic rx     = 1'b1;
  int   cyc    = 0;

  recepcion_if bus ();
  recepcion #(.CLKS_PER_BIT(CPB)) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .rx     (rx),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Monitor: capture every done pulse and count status pulses
  logic [7:0] got_q[$];
  int done_count = 0, ferr_count = 0, perr_count = 0, last_done_cyc = 0;
  always @(negedge clk_in) begin
    if (bus.done) begin
      got_q.push_back(bus.dout);
      done_count++;
      last_done_cyc = cyc;
    end
    if (bus.frame_err) ferr_count++;
`ifdef RECEPCION_PARITY_EN
    if (bus.par_err) perr_count++;
`endif
  end

  logic [7:0] exp_q[$];
  int rd_idx = 0;
  int vectors = 0, miscompares = 0;
  int start_cyc = 0;

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clk_in);
    rx = 1'b0;
    start_cyc = cyc;
    repeat (CPB) @(negedge clk_in);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk_in);
    end
`ifdef RECEPCION_PARITY_EN
    rx = ^b;
    repeat (CPB) @(negedge clk_in);
`endif
    rx = stop_bit;
    repeat (CPB) @(negedge clk_in);
    $display("frame 0x%02h sent, stop=%0d", b, stop_bit);
  endtask

  task automatic pulse_rd();
    @(negedge clk_in);
    bus.rd = 1'b1;
    @(negedge clk_in);
    bus.rd = 1'b0;
  endtask

  task automatic drain_scoreboard(input string name);
    logic [7:0] e;
    while (rd_idx < got_q.size()) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL %s unexpected_byte: got %02h required none", name, got_q[rd_idx]);
      end else begin
        e = exp_q.pop_front();
        if (got_q[rd_idx] !== e) begin
          miscompares++;
          $display("FAIL %s byte: got %02h required %02h", name, got_q[rd_idx], e);
        end
      end
      rd_idx++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s missing_bytes: got %0d outstanding required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (5) @(negedge clk_in);
    vectors++;
    if ({bus.dout, bus.avail, bus.done, bus.busy, bus.frame_err, bus.overrun} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got dout=%02h av=%b dn=%b bz=%b fe=%b ov=%b required all 0",
               bus.dout, bus.avail, bus.done, bus.busy, bus.frame_err, bus.overrun);
    end
    reset = 1'b1;
    repeat (5) @(negedge clk_in);
  endtask

  task automatic test_single();
    int d0, f0, lat;
    d0 = done_count; f0 = ferr_count;
    exp_q.push_back(8'h33);
    send_frame(8'h33, 1'b1);
    repeat (4) @(negedge clk_in);
    drain_scoreboard("single");
    vectors++;
    if (done_count - d0 != 1) begin
      miscompares++;
      $display("FAIL single_done_count: got %0d required 1", done_count - d0);
    end
    lat = last_done_cyc - start_cyc;
    vectors++;
    if (lat < LAT - 1 || lat > LAT + 1) begin
      miscompares++;
      $display("FAIL single_latency: got %0d required %0d+/-1", lat, LAT);
    end
    vectors++;
    if ({bus.avail, bus.busy, bus.overrun} !== 3'b100 || ferr_count != f0) begin
      miscompares++;
      $display("FAIL single_status: got av=%b bz=%b ov=%b ferr=%0d required av=1 bz=0 ov=0 ferr=0",
               bus.avail, bus.busy, bus.overrun, ferr_count - f0);
    end
    pulse_rd();
    vectors++;
    if (bus.avail !== 1'b0) begin
      miscompares++;
      $display("FAIL single_rd_clears: got avail=%b required 0", bus.avail);
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_count;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    fork
      begin
        send_frame(8'hA5, 1'b1);
        send_frame(8'h5A, 1'b1);
      end
      begin
        for (int k = 1; k <= 2; k++) begin
          for (int w = 0; w < 600 && done_count < d0 + k; w++) @(negedge clk_in);
          vectors++;
          if (done_count < d0 + k) begin
            miscompares++;
            $display("FAIL b2b_timeout: got %0d done pulses required %0d", done_count - d0, k);
          end
          pulse_rd();
        end
      end
    join
    repeat (4) @(negedge clk_in);
    drain_scoreboard("b2b");
    vectors++;
    if ({bus.overrun, bus.avail, bus.busy} !== 3'b000 || bus.dout !== 8'h5A) begin
      miscompares++;
      $display("FAIL b2b_final: got ov=%b av=%b bz=%b dout=%02h required 0 0 0 5a",
               bus.overrun, bus.avail, bus.busy, bus.dout);
    end
  endtask

  task automatic test_frame_error();
    int d0, f0;
    d0 = done_count; f0 = ferr_count;
    send_frame(8'h3C, 1'b0);
    repeat (39 * CPB) @(negedge clk_in);
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL ferr_break_busy: got %b required 1", bus.busy);
    end
    rx = 1'b1;
    repeat (6) @(negedge clk_in);
    drain_scoreboard("ferr");
    vectors++;
    if (ferr_count - f0 != 1 || done_count != d0) begin
      miscompares++;
      $display("FAIL ferr_pulses: got ferr=%0d done=%0d required ferr=1 done=0",
               ferr_count - f0, done_count - d0);
    end
    vectors++;
    if (bus.dout !== 8'h5A || bus.busy !== 1'b0 || bus.avail !== 1'b0) begin
      miscompares++;
      $display("FAIL ferr_hold: got dout=%02h bz=%b av=%b required dout=5a bz=0 av=0",
               bus.dout, bus.busy, bus.avail);
    end
  endtask

  task automatic test_glitch();
    int d0, f0;
    d0 = done_count; f0 = ferr_count;
    @(negedge clk_in);
    rx = 1'b0;
    repeat (5) @(negedge clk_in);
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL glitch_busy: got %b required 1", bus.busy);
    end
    rx = 1'b1;
    repeat (20) @(negedge clk_in);
    vectors++;
    if (bus.busy !== 1'b0 || done_count != d0 || ferr_count != f0) begin
      miscompares++;
      $display("FAIL glitch_reject: got bz=%b done=%0d ferr=%0d required 0 0 0",
               bus.busy, done_count - d0, ferr_count - f0);
    end
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    repeat (4) @(negedge clk_in);
    drain_scoreboard("glitch");
    pulse_rd();
  endtask

  task automatic test_overrun();
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    exp_q.push_back(8'h22);
    send_frame(8'h22, 1'b1);
    repeat (4) @(negedge clk_in);
    drain_scoreboard("overrun");
    vectors++;
    if ({bus.overrun, bus.avail} !== 2'b11 || bus.dout !== 8'h22) begin
      miscompares++;
      $display("FAIL overrun_set: got ov=%b av=%b dout=%02h required 1 1 22",
               bus.overrun, bus.avail, bus.dout);
    end
    pulse_rd();
    vectors++;
    if ({bus.overrun, bus.avail} !== 2'b00) begin
      miscompares++;
      $display("FAIL overrun_rd_clear: got ov=%b av=%b required 0 0", bus.overrun, bus.avail);
    end
  endtask

  task automatic test_reset_mid_frame();
    int d0;
    d0 = done_count;
    @(negedge clk_in);
    rx = 1'b0;
    repeat (CPB) @(negedge clk_in);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk_in);
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_busy_before: got %b required 1", bus.busy);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk_in);
    vectors++;
    if ({bus.dout, bus.avail, bus.done, bus.busy, bus.frame_err, bus.overrun} !== 13'd0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got dout=%02h av=%b dn=%b bz=%b fe=%b ov=%b required all 0",
               bus.dout, bus.avail, bus.done, bus.busy, bus.frame_err, bus.overrun);
    end
    reset = 1'b1;
    repeat (8 * CPB) @(negedge clk_in);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    repeat (4) @(negedge clk_in);
    drain_scoreboard("midreset");
    vectors++;
    if (done_count - d0 != 1 || bus.dout !== 8'h0F) begin
      miscompares++;
      $display("FAIL midreset_only_new: got done=%0d dout=%02h required 1 0f",
               done_count - d0, bus.dout);
    end
    pulse_rd();
  endtask

`ifdef RECEPCION_PARITY_EN
  task automatic test_parity();
    int d0, p0;
    logic [7:0] b;
    d0 = done_count; p0 = perr_count;
    b = 8'h07;
    @(negedge clk_in);
    rx = 1'b0;
    repeat (CPB) @(negedge clk_in);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk_in);
    end
    rx = 1'b0;
    repeat (CPB) @(negedge clk_in);
    rx = 1'b1;
    repeat (CPB + 4) @(negedge clk_in);
    $display("frame 0x07 sent with parity 0");
    drain_scoreboard("parity");
    vectors++;
    if (perr_count - p0 != 1 || done_count != d0 || bus.dout !== 8'h0F || bus.avail !== 1'b0) begin
      miscompares++;
      $display("FAIL parity_err: got perr=%0d done=%0d dout=%02h av=%b required 1 0 0f 0",
               perr_count - p0, done_count - d0, bus.dout, bus.avail);
    end
  endtask
`endif

  initial begin
    bus.rd = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_error();
    test_glitch();
    test_overrun();
    test_reset_mid_frame();
`ifdef RECEPCION_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
